// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle between a controlling FSM and the restoring divider.
// The controller drives operands and start; the divider returns status and registered results.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one shift/trial-subtract/restore row per clock,
// WIDTH rows per operation, with registered results and a divide-by-zero shortcut.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    count;
    logic             dbz;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // P is kept below the divisor, so its top bit never carries information out of the shift.
    always_comb begin
        shifted = {p[WIDTH-1:0], q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            p               <= '0;
            q               <= '0;
            dvsr            <= '0;
            count           <= '0;
            dbz             <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // Results publish in DONE even when a new request is captured on the same edge.
                    if (state == DONE) begin
                        bus.done        <= 1'b1;
                        bus.quotient    <= dbz ? '1 : q;
                        bus.remainder   <= dbz ? q : p[WIDTH-1:0];
                        bus.div_by_zero <= dbz;
                    end
                    if (bus.start) begin
                        dvsr  <= bus.divisor;
                        q     <= bus.dividend;
                        p     <= '0;
                        count <= '0;
                        dbz   <= (bus.divisor == '0);
                        if (state == IDLE) begin
                            bus.div_by_zero <= 1'b0;
                        end
                        if (bus.divisor == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        p <= trial;
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        p <= shifted;
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider at WIDTH=8: latency, results,
// divide-by-zero, back-to-back starts, ignored starts, reset abort and a small sweep.
module tb_seq_restoring_divider;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    seq_restoring_divider_if #(.WIDTH(8)) bus ();

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one sampling edge; returns 1ns after that edge.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = bus.busy ? 1 : 0;
        do begin
            tick();
            cycles++;
            if (bus.busy) busy_cycles++;
        end while (!bus.done && cycles < 40);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0d expected 0", bus.busy); end
        compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %0d expected 0", bus.done); end
        compared++; if (bus.quotient !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_quotient: got %0d expected 0", bus.quotient); end
        compared++; if (bus.remainder !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_remainder: got %0d expected 0", bus.remainder); end
        compared++; if (bus.div_by_zero !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dbz: got %0d expected 0", bus.div_by_zero); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cycles, busy_cycles;
        apply_stimulus(8'd100, 8'd7);
        wait_done(cycles, busy_cycles);
        compared++; if (bus.done !== 1'b1 || cycles != 9) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d clocks done=%0d expected 9 clocks done=1", cycles, bus.done); end
        compared++; if (busy_cycles != 8) begin mismatched++; $display("[TB] FAIL basic_busy_len: got %0d expected 8", busy_cycles); end
        compared++; if (bus.quotient !== 8'd14) begin mismatched++; $display("[TB] FAIL basic_quotient: got %0d expected 14", bus.quotient); end
        compared++; if (bus.remainder !== 8'd2) begin mismatched++; $display("[TB] FAIL basic_remainder: got %0d expected 2", bus.remainder); end
        compared++; if (bus.div_by_zero !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_dbz: got %0d expected 0", bus.div_by_zero); end
        tick();
        compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_pulse: got %0d expected 0", bus.done); end
        compared++; if (bus.quotient !== 8'd14) begin mismatched++; $display("[TB] FAIL basic_quotient_held: got %0d expected 14", bus.quotient); end
    endtask

    task automatic test_back_to_back();
        int cycles, busy_cycles;
        apply_stimulus(8'd255, 8'd1);
        for (int i = 0; i < 8; i++) tick();
        // The block now sits in its DONE state; this request lands on the publishing edge.
        bus.start    = 1'b1;
        bus.dividend = 8'd5;
        bus.divisor  = 8'd9;
        tick();
        bus.start = 1'b0;
        compared++; if (bus.done !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_first_done: got %0d expected 1", bus.done); end
        compared++; if (bus.quotient !== 8'd255) begin mismatched++; $display("[TB] FAIL b2b_first_quotient: got %0d expected 255", bus.quotient); end
        compared++; if (bus.remainder !== 8'd0) begin mismatched++; $display("[TB] FAIL b2b_first_remainder: got %0d expected 0", bus.remainder); end
        compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_no_gap_busy: got %0d expected 1", bus.busy); end
        wait_done(cycles, busy_cycles);
        compared++; if (bus.done !== 1'b1 || cycles != 9) begin mismatched++; $display("[TB] FAIL b2b_second_latency: got %0d clocks done=%0d expected 9 clocks done=1", cycles, bus.done); end
        compared++; if (bus.quotient !== 8'd0) begin mismatched++; $display("[TB] FAIL b2b_second_quotient: got %0d expected 0", bus.quotient); end
        compared++; if (bus.remainder !== 8'd5) begin mismatched++; $display("[TB] FAIL b2b_second_remainder: got %0d expected 5", bus.remainder); end
        tick();
    endtask

    task automatic test_div_by_zero();
        int cycles, busy_cycles;
        apply_stimulus(8'd37, 8'd0);
        wait_done(cycles, busy_cycles);
        compared++; if (bus.done !== 1'b1 || cycles != 1) begin mismatched++; $display("[TB] FAIL dbz_latency: got %0d clocks done=%0d expected 1 clock done=1", cycles, bus.done); end
        compared++; if (bus.quotient !== 8'hFF) begin mismatched++; $display("[TB] FAIL dbz_quotient: got %0d expected 255", bus.quotient); end
        compared++; if (bus.remainder !== 8'd37) begin mismatched++; $display("[TB] FAIL dbz_remainder: got %0d expected 37", bus.remainder); end
        compared++; if (bus.div_by_zero !== 1'b1) begin mismatched++; $display("[TB] FAIL dbz_flag: got %0d expected 1", bus.div_by_zero); end
        compared++; if (busy_cycles != 0) begin mismatched++; $display("[TB] FAIL dbz_busy: got %0d expected 0", busy_cycles); end
        tick();
        compared++; if (bus.div_by_zero !== 1'b1) begin mismatched++; $display("[TB] FAIL dbz_flag_held: got %0d expected 1", bus.div_by_zero); end
        apply_stimulus(8'd200, 8'd10);
        compared++; if (bus.div_by_zero !== 1'b0) begin mismatched++; $display("[TB] FAIL dbz_clear_on_start: got %0d expected 0", bus.div_by_zero); end
        wait_done(cycles, busy_cycles);
        compared++; if (bus.done !== 1'b1 || cycles != 9) begin mismatched++; $display("[TB] FAIL dbz_next_latency: got %0d clocks expected 9", cycles); end
        compared++; if (bus.quotient !== 8'd20) begin mismatched++; $display("[TB] FAIL dbz_next_quotient: got %0d expected 20", bus.quotient); end
        compared++; if (bus.remainder !== 8'd0) begin mismatched++; $display("[TB] FAIL dbz_next_remainder: got %0d expected 0", bus.remainder); end
        compared++; if (bus.div_by_zero !== 1'b0) begin mismatched++; $display("[TB] FAIL dbz_next_flag: got %0d expected 0", bus.div_by_zero); end
        tick();
    endtask

    task automatic test_ignore_start();
        int cycles, busy_cycles, extra_done;
        apply_stimulus(8'd200, 8'd3);
        for (int i = 0; i < 3; i++) tick();
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd2;
        tick();
        bus.dividend = 8'd50;
        bus.divisor  = 8'd1;
        tick();
        bus.start = 1'b0;
        wait_done(cycles, busy_cycles);
        compared++; if (bus.done !== 1'b1 || cycles != 4) begin mismatched++; $display("[TB] FAIL ignore_latency: got %0d clocks done=%0d expected 4 clocks done=1", cycles, bus.done); end
        compared++; if (bus.quotient !== 8'd66) begin mismatched++; $display("[TB] FAIL ignore_quotient: got %0d expected 66", bus.quotient); end
        compared++; if (bus.remainder !== 8'd2) begin mismatched++; $display("[TB] FAIL ignore_remainder: got %0d expected 2", bus.remainder); end
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) extra_done++;
        end
        compared++; if (extra_done != 0) begin mismatched++; $display("[TB] FAIL ignore_single_done: got %0d extra done pulses expected 0", extra_done); end
    endtask

    task automatic test_reset_abort();
        int cycles, busy_cycles, stray_done;
        apply_stimulus(8'd100, 8'd7);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %0d expected 0", bus.busy); end
        compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done: got %0d expected 0", bus.done); end
        compared++; if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin mismatched++; $display("[TB] FAIL abort_results: got q=%0d r=%0d expected q=0 r=0", bus.quotient, bus.remainder); end
        stray_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done || bus.busy) stray_done++;
        end
        compared++; if (stray_done != 0) begin mismatched++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", stray_done); end
        apply_stimulus(8'd100, 8'd7);
        wait_done(cycles, busy_cycles);
        compared++; if (bus.done !== 1'b1 || cycles != 9) begin mismatched++; $display("[TB] FAIL abort_fresh_latency: got %0d clocks expected 9", cycles); end
        compared++; if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin mismatched++; $display("[TB] FAIL abort_fresh_result: got q=%0d r=%0d expected q=14 r=2", bus.quotient, bus.remainder); end
        tick();
    endtask

    task automatic test_sweep();
        logic [7:0] va [10] = '{8'd255, 8'd254, 8'd128, 8'd7, 8'd0, 8'd250, 8'd1, 8'd99, 8'd255, 8'd143};
        logic [7:0] vb [10] = '{8'd255, 8'd255, 8'd2, 8'd7, 8'd5, 8'd16, 8'd1, 8'd100, 8'd128, 8'd11};
        logic [7:0] vq [10] = '{8'd1, 8'd0, 8'd64, 8'd1, 8'd0, 8'd15, 8'd1, 8'd0, 8'd1, 8'd13};
        logic [7:0] vr [10] = '{8'd0, 8'd254, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd99, 8'd127, 8'd0};
        int cycles, busy_cycles;
        logic [7:0] a, b;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(va[i], vb[i]);
            wait_done(cycles, busy_cycles);
            compared++;
            if (bus.done !== 1'b1 || cycles != 9 || bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin
                mismatched++;
                $display("[TB] FAIL vector_%0d: got q=%0d r=%0d in %0d clocks expected q=%0d r=%0d in 9", i, bus.quotient, bus.remainder, cycles, vq[i], vr[i]);
            end
        end
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 1));
            apply_stimulus(a, b);
            wait_done(cycles, busy_cycles);
            compared++;
            if (bus.done !== 1'b1 || cycles != 9 || bus.quotient !== a / b || bus.remainder !== a % b) begin
                mismatched++;
                $display("[TB] FAIL random_%0d: %0d/%0d got q=%0d r=%0d in %0d clocks expected q=%0d r=%0d in 9", i, a, b, bus.quotient, bus.remainder, cycles, a / b, a % b);
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 8'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_ignore_start();
        test_reset_abort();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
